gf_reduce_seq: RTL

- Iterative polynomial reducer that sits directly downstream of the carry-less/integer multiplier stage.
- Consumes its 2*DATA_WIDTH product and, in GF mode, reduces it modulo an irreducible polynomial of degree DATA_WIDTH to form a GF(2^DATA_WIDTH) field element.
- In integer mode the product passes through unchanged.
- Processes one product bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/gf_reduce_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/gf_reduce_seq.sv
// Bit-serial GF(2^DATA_WIDTH) reducer with valid/ready handshakes and integer bypass.
// Optional early termination when the upper half is clear: define GF_REDUCE_EARLY_EXIT_EN.
module gf_reduce_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    gf_option,
  input  logic [2*DATA_WIDTH-1:0] prod,
  input  logic [DATA_WIDTH-1:0]   poly,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out,
  output logic                    busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(2 * W);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [2*W-1:0]  r, r_nxt;
  logic [W:0]      p, p_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2*W-1:0]  p_shift;
  logic            early_exit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // r is untouched in bypass, so it carries the latched product in both modes
  assign out       = out_valid ? r : '0;

  assign p_shift = {{(W-1){1'b0}}, p} << (cnt - CW'(W));

`ifdef GF_REDUCE_EARLY_EXIT_EN
  // Bits above cnt are already cleared, so the whole upper half stands in for r[cnt:W]
  assign early_exit = (r[2*W-1:W] == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      p     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      p     <= p_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    p_nxt     = p;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          r_nxt     = prod;
          p_nxt     = {1'b1, poly};
          cnt_nxt   = CW'(2 * W - 1);
          state_nxt = gf_option ? REDUCE : DONE;
        end
      end
      REDUCE: begin
        if (early_exit) begin
          state_nxt = DONE;
        end else begin
          if (r[cnt]) begin
            r_nxt = r ^ p_shift;
          end
          if (cnt == CW'(W)) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
